expr_char_gen: RTL
==================

// Module: expr_char_gen
// PURPOSE
//  Transmit side of the single-digit-expression character stream. Accepts a packed
//  expression (digits + operators), serialises it as ASCII one byte per accepted beat
//  (digit, op, digit, ..., digit) on a valid/ready link feeding the expression recogniser.
//  Used as stimulus source and loopback partner for the recogniser.
// PARAMETERS
//  MAX_TERMS  8   max digit count per expression (1..15)
//  RES_W      32  width of evaluated result (EVAL_EN only); 9^8 fits
// PORTS
//  clk        in   1              rising-edge clock
//  clr_n      in   1              async active-low reset
//  start      in   1              load request; sampled only in IDLE
//  num_terms  in   4              digit count n (valid 1..MAX_TERMS)
//  digits     in   4*MAX_TERMS    BCD digits, term i at [4i+3:4i]
//  ops        in   MAX_TERMS-1    op i between term i and i+1: 0='+'(8'd43), 1='*'(8'd42)
//  out        out  8              ASCII byte
//  out_valid  out  1              byte on out is valid
//  out_ready  in   1              sink accepts byte when out_valid&&out_ready
//  out_last   out  1              qualifies final byte of expression
//  busy       out  1              high from accepted start until done
//  done       out  1              1-cycle pulse after last byte accepted
//  err        out  1              1-cycle pulse: start rejected
//  result     out  RES_W          evaluated value (EVAL_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync-released by clk): state IDLE; out=0, out_valid=0,
//    out_last=0, busy=0, done=0, err=0, result=0. Reset mid-stream aborts, no done.
//  - FSM: IDLE -> DIGIT on valid start; DIGIT -> OP on handshake if idx<n-1;
//    OP -> DIGIT on handshake (idx++); DIGIT -> DONE on handshake if idx==n-1;
//    DONE -> IDLE after 1 cycle (done=1 there).
//  - start in IDLE: capture num_terms/digits/ops into regs; first byte valid next cycle.
//  - Reject (err pulse, stay IDLE, no bytes): num_terms==0, num_terms>MAX_TERMS,
//    or any used digit >9.
//  - DIGIT emits 8'd48+digit[idx]; OP emits op-char; out_last=1 only on DIGIT idx==n-1.
//  - Stall: while out_valid&&!out_ready, out/out_last held stable; no byte dropped or
//    duplicated. out_valid never drops without handshake.
//  - Throughput 1 byte/cycle with out_ready tied high; n terms -> 2n-1 beats.
//  - start while busy: ignored, no err. start in DONE cycle ignored.
//  - Input buses after capture may change freely; no effect on current stream.
// CONFIGURATION
//  EVAL_EN defined: evaluate with '*' precedence over '+', left-to-right, on each
//   handshake: digit -> prod=prod*d (prod=d after '+'/first); '+' -> sum+=prod,prod=1.
//   On last digit handshake result<=sum+prod (mod 2^RES_W), stable from done until
//   next accepted start. EVAL_EN undefined: result tied 0, no multiplier.
// STRUCTURE
//  - Package expr_pkg: ASCII constants (CH_0=48, CH_ADD=43, CH_MUL=42), FSM state enum
//    (S_IDLE,S_DIGIT,S_OP,S_DONE), op-code constants OP_ADD=0/OP_MUL=1.
//  - Sub-module expr_eval (instantiated under EVAL_EN): sum/prod accumulator driven
//    by beat strobe, char class, digit value.
// TESTING
//  1 reset: clr_n=0 mid-stream -> all outputs 0 same cycle; release -> IDLE, no done.
//  2 n=3 digits 0,1,2 ops '*','+', out_ready=1 -> bytes 48,42,49,43,50 consecutive,
//    out_last on 50, done next cycle; EVAL_EN: result=2.
//  3 same with out_ready toggled 1,0,0,1,... -> same 5 bytes, held stable in stalls.
//  4 n=1 digit 9 -> single byte 57 with out_last; EVAL_EN result=9.
//  5 digit[1]=4'hA or num_terms=0 -> err pulse, out_valid stays 0, busy 0.
//  6 start pulsed while busy -> ignored, stream unchanged; EVAL_EN n=8 all '9' with '*'
//    -> result=43046721.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants and FSM state encoding for the expression character stream.
package expr_pkg;
  localparam logic [7:0] CH_0   = 8'd48;
  localparam logic [7:0] CH_ADD = 8'd43;
  localparam logic [7:0] CH_MUL = 8'd42;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT,
    S_OP,
    S_DONE
  } state_e;

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? CH_MUL : CH_ADD;
  endfunction
endpackage

// File: rtl/expr_eval.sv
// Sum-of-products accumulator: '*' binds tighter than '+', evaluated left to right
// one accepted beat at a time.
module expr_eval #(
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             beat,
  input  logic             is_digit,
  input  logic             is_last,
  input  logic             add_op,
  input  logic [3:0]       digit,
  output logic [RES_W-1:0] result
);
  logic [RES_W-1:0] sum_q, prod_q, result_q;
  logic [RES_W-1:0] prod_mul;

  // prod restarts at 1 so the digit after a '+' simply becomes the new product
  assign prod_mul = prod_q * RES_W'(digit);
  assign result   = result_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sum_q    <= '0;
      prod_q   <= RES_W'(1);
      result_q <= '0;
    end else if (clear) begin
      sum_q  <= '0;
      prod_q <= RES_W'(1);
    end else if (beat) begin
      if (is_digit) begin
        prod_q <= prod_mul;
        if (is_last) result_q <= sum_q + prod_mul;
      end else if (add_op) begin
        sum_q  <= sum_q + prod_q;
        prod_q <= RES_W'(1);
      end
    end
  end
endmodule

// File: rtl/expr_char_gen.sv
// Serialises a packed single-digit expression as ASCII bytes on a valid/ready link.
// Define EVAL_EN to also evaluate the expression into result.
module expr_char_gen
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int RES_W     = 32
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [RES_W-1:0]       result
);
  localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d, n_q, n_d;
  logic [15:0][3:0] dig_q, dig_d, dig_in;
  logic [15:0]      ops_q, ops_d, ops_in;
  logic [15:0]      bad_digit;
  logic             err_q, err_d;
  logic             start_ok, last_digit, hs;
  logic [3:0]       cur_digit;
  logic             cur_op;

  // Capture buses are widened to 16 entries so a 4-bit index never runs off the end
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_in
      if (gi < MAX_TERMS) begin : g_dig
        assign dig_in[gi]    = digits[4*gi +: 4];
        assign bad_digit[gi] = (4'(gi) < num_terms) && (dig_in[gi] > 4'd9);
      end else begin : g_dig_pad
        assign dig_in[gi]    = 4'd0;
        assign bad_digit[gi] = 1'b0;
      end
      if (gi < MAX_TERMS - 1) begin : g_op
        assign ops_in[gi] = ops[gi];
      end else begin : g_op_pad
        assign ops_in[gi] = 1'b0;
      end
    end
  endgenerate

  assign start_ok   = (num_terms != 4'd0) && (num_terms <= MAX_N) && !(|bad_digit);
  assign last_digit = (idx_q == n_q - 4'd1);
  assign cur_digit  = dig_q[idx_q];
  assign cur_op     = ops_q[idx_q];
  assign hs         = out_valid && out_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      dig_q   <= '0;
      ops_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      dig_q   <= dig_d;
      ops_q   <= ops_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    dig_d   = dig_q;
    ops_d   = ops_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            n_d     = num_terms;
            dig_d   = dig_in;
            ops_d   = ops_in;
            idx_d   = '0;
            state_d = S_DIGIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DIGIT: if (hs) state_d = last_digit ? S_DONE : S_OP;
      S_OP: begin
        if (hs) begin
          state_d = S_DIGIT;
          idx_d   = idx_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so they hold through stalls
  always_comb begin
    out       = 8'd0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      S_DIGIT: begin
        out       = CH_0 + {4'd0, cur_digit};
        out_valid = 1'b1;
        out_last  = last_digit;
      end
      S_OP: begin
        out       = op_char(cur_op);
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

`ifdef EVAL_EN
  logic eval_clear, eval_add;
  assign eval_clear = (state_q == S_IDLE) && start && start_ok;
  assign eval_add   = (state_q == S_OP) && (cur_op == OP_ADD);

  expr_eval #(.RES_W(RES_W)) u_eval (
    .clk     (clk),
    .clr_n   (clr_n),
    .clear   (eval_clear),
    .beat    (hs),
    .is_digit(state_q == S_DIGIT),
    .is_last (last_digit),
    .add_op  (eval_add),
    .digit   (cur_digit),
    .result  (result)
  );
`else
  assign result = '0;
`endif
endmodule
